fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction buffer on the consuming side of the fetch-result interface. It accepts fetch packs (two 32-bit instruction slots, per-slot valids, aligned PC, branch-predict pack) and splits them into per-instruction entries tagged with PC and prediction. It presents up to two instructions per cycle, in program order, to decode. It drives the stall that throttles fetch, and it clears on flush.

## Interface
- `DEPTH`, 16: number of instruction entries. Power of two, at least 4.
- `clock`  in  1  sole clock; every register samples on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_i_flush`  in  1  discards all contents.
- `io_i_fetch_pack_valid`  in  1  the fetch pack is valid.
- `io_i_fetch_pack_bits_valids_0/1`  in  1 each  per-slot valid.
- `io_i_fetch_pack_bits_pc`  in  64  8-byte-aligned pack PC.
- `io_i_fetch_pack_bits_insts_0/1`  in  32 each  slot instructions.
- `io_i_fetch_pack_bits_branch_predict_pack_valid/taken/select`  in  1 each  prediction; `select` gives the slot index of the predicted branch.
- `io_i_fetch_pack_bits_branch_predict_pack_target`  in  64  predicted target.
- `io_i_fetch_pack_bits_branch_predict_pack_branch_type`  in  4  branch type.
- `io_o_stall`  out  1  fetch must hold this cycle; feeds the fetch stage's stall input.
- `io_i_decode_ready`  in  1  decode consumes every presented valid slot this cycle.
- `io_o_valid_0/1`  out  1 each  output slot valid.
- `io_o_inst_0/1`  out  32 each  output instructions.
- `io_o_pc_0/1`  out  64 each  output PCs.
- `io_o_pred_taken_0/1`  out  1 each  predicted-taken tag per output slot.
- `io_o_pred_target_0/1`  out  64 each  predicted target per output slot.
- `io_o_pred_type_0/1`  out  4 each  branch type per output slot.

## Operation
- **Storage:** circular buffer of DEPTH entries. Each entry holds {inst, pc, pred_taken, pred_target, pred_type}.
- **Pointers:** head and tail pointers of log2(DEPTH) bits wrap modulo DEPTH. A separate count register of log2(DEPTH)+1 bits tracks occupancy.
- **Enqueue fire:** `io_i_fetch_pack_valid & ~io_o_stall & ~io_i_flush`.
- **Enqueue writes:** on fire, the valid slots are written in order, slot 0 first, at tail and tail+1. The tail advances by the number of valid slots (0, 1 or 2).
- **Compaction:** a pack with only `valids_1` set writes one entry, at the tail.
- **Entry PC:** slot k gets `pc + 4*k`.
- **Entry prediction:** `pred_taken = bp_valid & bp_taken & (bp_select == k)`. `pred_target` and `pred_type` are copied unconditionally.
- **Stall:** `io_o_stall = (DEPTH - count) < 2`. It uses the registered count, ignores a same-cycle dequeue, and is never gated by flush.
- **Output valids:** `io_o_valid_0 = (count >= 1) & ~io_i_flush`; `io_o_valid_1 = (count >= 2) & ~io_i_flush`.
- **Output data:** slot 0 shows entry[head] and slot 1 shows entry[head+1]. Both are combinational from registered state. Data on invalid slots is don't-care.
- **Dequeue:** when `io_i_decode_ready` is high, the head advances by `io_o_valid_0 + io_o_valid_1`.
- **Count update:** count' = count + enq_n − deq_n. Simultaneous enqueue and dequeue are legal.
- **Flush:** takes priority over enqueue and dequeue. On the next edge head, tail and count go to 0. Entry contents are not cleared.
- **Reset:** head = tail = count = 0. Outputs after reset: every `io_o_valid_*` = 0 and `io_o_stall` = 0. Data outputs reflect entry[0] and entry[1], which are uninitialised and don't-care.

## Timing
- Enqueue-to-output latency is 1 cycle: an entry written at edge N is visible at the outputs after edge N.
- No combinational path from `io_i_fetch_pack_*` to any output. The only combinational input-to-output path is `io_i_flush` to `io_o_valid_*`.
- Throughput is 2 instructions per cycle in and out, sustained when count ≤ DEPTH−2.
- **Full boundary:** count = DEPTH−1 asserts stall, even though one slot is free.
- **Wrap-around:** a two-slot write or read across the DEPTH−1 → 0 boundary is legal.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous).

## Configuration
- **`FETCH_QUEUE_STATS_EN` defined:** adds output `io_o_stall_cycles` (32 bits). It counts cycles with `io_i_fetch_pack_valid & io_o_stall`, resets to 0, saturates at 2^32−1, and is not cleared by flush.
- **`FETCH_QUEUE_STATS_EN` undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Two-slot enqueue:** after reset, pack pc=0x80000000 with both valids, insts 0x00000013 and 0x00100093; decode_ready=0. Next cycle: valid_0 = valid_1 = 1, pc_0 = 0x80000000, pc_1 = 0x80000004, count = 2.
- **Single-slot compaction:** pack pc=0x80000008 with only valids_1. One entry is written with pc 0x8000000C and appears in output slot 0.
- **Prediction tagging:** bp valid=1, taken=1, select=0, target=0x80001000. Slot 0 shows pred_taken_0 = 1 with target 0x80001000; slot 1 entry has pred_taken = 0.
- **Fill and stall:** DEPTH=16, decode_ready=0, enqueue two-slot packs. After 8 packs stall=1; a 9th valid pack is not written. Then assert decode_ready for one cycle: count drops to 14 and stall deasserts.
- **Flush with simultaneous traffic:** flush together with a valid enqueue and decode_ready, with count=6. valid_* = 0 during the flush cycle; next cycle count = 0, the pack is dropped, and no dequeue occurs.
- **Wrap-around and async reset:** sustain enqueue and dequeue for 40 cycles and check in-order PCs across the wrap. Then drop `reset` mid-cycle: valid_* fall to 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer splitting fetch packs into per-instruction entries for decode.
// Optional FETCH_QUEUE_STATS_EN adds io_o_stall_cycles, a saturating count of fetch-stalled cycles.
module fetch_queue #(
   parameter int DEPTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_i_flush,
   input  logic        io_i_fetch_pack_valid,
   input  logic        io_i_fetch_pack_bits_valids_0,
   input  logic        io_i_fetch_pack_bits_valids_1,
   input  logic [63:0] io_i_fetch_pack_bits_pc,
   input  logic [31:0] io_i_fetch_pack_bits_insts_0,
   input  logic [31:0] io_i_fetch_pack_bits_insts_1,
   input  logic        io_i_fetch_pack_bits_branch_predict_pack_valid,
   input  logic        io_i_fetch_pack_bits_branch_predict_pack_taken,
   input  logic        io_i_fetch_pack_bits_branch_predict_pack_select,
   input  logic [63:0] io_i_fetch_pack_bits_branch_predict_pack_target,
   input  logic [3:0]  io_i_fetch_pack_bits_branch_predict_pack_branch_type,
   output logic        io_o_stall,
`ifdef FETCH_QUEUE_STATS_EN
   output logic [31:0] io_o_stall_cycles,
`endif
   input  logic        io_i_decode_ready,
   output logic        io_o_valid_0,
   output logic        io_o_valid_1,
   output logic [31:0] io_o_inst_0,
   output logic [31:0] io_o_inst_1,
   output logic [63:0] io_o_pc_0,
   output logic [63:0] io_o_pc_1,
   output logic        io_o_pred_taken_0,
   output logic        io_o_pred_taken_1,
   output logic [63:0] io_o_pred_target_0,
   output logic [63:0] io_o_pred_target_1,
   output logic [3:0]  io_o_pred_type_0,
   output logic [3:0]  io_o_pred_type_1
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0] inst_q   [DEPTH];
   logic [63:0] pc_q     [DEPTH];
   logic        taken_q  [DEPTH];
   logic [63:0] target_q [DEPTH];
   logic [3:0]  type_q   [DEPTH];
   logic [AW-1:0] head, tail, head_1, tail_1;
   logic [AW:0]   count, enq_n, deq_n;
   logic          enq, v0, v1, taken_0, taken_1, w_taken;
   logic [31:0]   w_inst;
   logic [63:0]   w_pc;
   assign v0 = io_i_fetch_pack_bits_valids_0;
   assign v1 = io_i_fetch_pack_bits_valids_1;
   assign head_1 = head + AW'(1);
   assign tail_1 = tail + AW'(1);
   assign io_o_stall   = count > (AW+1)'(DEPTH - 2);
   assign io_o_valid_0 = (count != '0) & ~io_i_flush;
   assign io_o_valid_1 = (count > (AW+1)'(1)) & ~io_i_flush;
   assign enq   = io_i_fetch_pack_valid & ~io_o_stall & ~io_i_flush;
   assign enq_n = enq ? (AW+1)'(v0) + (AW+1)'(v1) : '0;
   assign deq_n = io_i_decode_ready ? (AW+1)'(io_o_valid_0) + (AW+1)'(io_o_valid_1) : '0;
   assign taken_0 = io_i_fetch_pack_bits_branch_predict_pack_valid &
                    io_i_fetch_pack_bits_branch_predict_pack_taken &
                    ~io_i_fetch_pack_bits_branch_predict_pack_select;
   assign taken_1 = io_i_fetch_pack_bits_branch_predict_pack_valid &
                    io_i_fetch_pack_bits_branch_predict_pack_taken &
                    io_i_fetch_pack_bits_branch_predict_pack_select;
   // The first valid slot always lands at tail, which compacts a slot-1-only pack.
   assign w_inst  = v0 ? io_i_fetch_pack_bits_insts_0 : io_i_fetch_pack_bits_insts_1;
   assign w_pc    = v0 ? io_i_fetch_pack_bits_pc : io_i_fetch_pack_bits_pc + 64'd4;
   assign w_taken = v0 ? taken_0 : taken_1;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (io_i_flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + deq_n[AW-1:0];
         tail  <= tail + enq_n[AW-1:0];
         count <= count + enq_n - deq_n;
      end
   end
   always_ff @(posedge clock) begin
      if (enq & (v0 | v1)) begin
         inst_q[tail]   <= w_inst;
         pc_q[tail]     <= w_pc;
         taken_q[tail]  <= w_taken;
         target_q[tail] <= io_i_fetch_pack_bits_branch_predict_pack_target;
         type_q[tail]   <= io_i_fetch_pack_bits_branch_predict_pack_branch_type;
      end
      if (enq & v0 & v1) begin
         inst_q[tail_1]   <= io_i_fetch_pack_bits_insts_1;
         pc_q[tail_1]     <= io_i_fetch_pack_bits_pc + 64'd4;
         taken_q[tail_1]  <= taken_1;
         target_q[tail_1] <= io_i_fetch_pack_bits_branch_predict_pack_target;
         type_q[tail_1]   <= io_i_fetch_pack_bits_branch_predict_pack_branch_type;
      end
   end
   assign io_o_inst_0        = inst_q[head];
   assign io_o_inst_1        = inst_q[head_1];
   assign io_o_pc_0          = pc_q[head];
   assign io_o_pc_1          = pc_q[head_1];
   assign io_o_pred_taken_0  = taken_q[head];
   assign io_o_pred_taken_1  = taken_q[head_1];
   assign io_o_pred_target_0 = target_q[head];
   assign io_o_pred_target_1 = target_q[head_1];
   assign io_o_pred_type_0   = type_q[head];
   assign io_o_pred_type_1   = type_q[head_1];
`ifdef FETCH_QUEUE_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         io_o_stall_cycles <= '0;
      else if (io_i_fetch_pack_valid & io_o_stall & ~&io_o_stall_cycles)
         io_o_stall_cycles <= io_o_stall_cycles + 32'd1;
   end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
   localparam int DEPTH = 16;
   typedef struct {
      logic [31:0] inst;
      logic [63:0] pc;
      logic        taken;
      logic [63:0] target;
      logic [3:0]  typ;
   } ent_t;
   logic clock = 0, reset = 0;
   logic flush, fv, v0, v1, bpv, bpt, bps, dr;
   logic [63:0] pc, tgt;
   logic [31:0] i0, i1;
   logic [3:0]  typ;
   logic stall, valid_0, valid_1, taken_0, taken_1;
   logic [31:0] inst_0, inst_1;
   logic [63:0] pc_0, pc_1, target_0, target_1;
   logic [3:0]  type_0, type_1;
   ent_t q[$];
   int n_chk = 0, n_pass = 0;
   always #5 clock = ~clock;
   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .io_i_flush(flush),
      .io_i_fetch_pack_valid(fv),
      .io_i_fetch_pack_bits_valids_0(v0), .io_i_fetch_pack_bits_valids_1(v1),
      .io_i_fetch_pack_bits_pc(pc),
      .io_i_fetch_pack_bits_insts_0(i0), .io_i_fetch_pack_bits_insts_1(i1),
      .io_i_fetch_pack_bits_branch_predict_pack_valid(bpv),
      .io_i_fetch_pack_bits_branch_predict_pack_taken(bpt),
      .io_i_fetch_pack_bits_branch_predict_pack_select(bps),
      .io_i_fetch_pack_bits_branch_predict_pack_target(tgt),
      .io_i_fetch_pack_bits_branch_predict_pack_branch_type(typ),
      .io_o_stall(stall), .io_i_decode_ready(dr),
      .io_o_valid_0(valid_0), .io_o_valid_1(valid_1),
      .io_o_inst_0(inst_0), .io_o_inst_1(inst_1),
      .io_o_pc_0(pc_0), .io_o_pc_1(pc_1),
      .io_o_pred_taken_0(taken_0), .io_o_pred_taken_1(taken_1),
      .io_o_pred_target_0(target_0), .io_o_pred_target_1(target_1),
      .io_o_pred_type_0(type_0), .io_o_pred_type_1(type_1)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   function automatic ent_t mk(input int k);
      ent_t e;
      e.inst   = k == 0 ? i0 : i1;
      e.pc     = pc + 64'(4 * k);
      e.taken  = bpv & bpt & (int'(bps) == k);
      e.target = tgt;
      e.typ    = typ;
      return e;
   endfunction
   task automatic compare();
      bit ev0, ev1;
      ev0 = q.size() >= 1 && !flush;
      ev1 = q.size() >= 2 && !flush;
      check("stall", stall, 64'((DEPTH - q.size()) < 2));
      check("valid_0", valid_0, 64'(ev0));
      check("valid_1", valid_1, 64'(ev1));
      if (ev0) begin
         check("inst_0", inst_0, q[0].inst);
         check("pc_0", pc_0, q[0].pc);
         check("taken_0", taken_0, q[0].taken);
         check("target_0", target_0, q[0].target);
         check("type_0", type_0, q[0].typ);
      end
      if (ev1) begin
         check("inst_1", inst_1, q[1].inst);
         check("pc_1", pc_1, q[1].pc);
         check("taken_1", taken_1, q[1].taken);
         check("target_1", target_1, q[1].target);
         check("type_1", type_1, q[1].typ);
      end
   endtask
   task automatic model_edge();
      bit e;
      e = fv && (DEPTH - q.size()) >= 2 && !flush;
      if (flush) q.delete();
      else begin
         if (dr) for (int i = 0; i < 2 && q.size() > 0; i++) void'(q.pop_front());
         if (e && v0) q.push_back(mk(0));
         if (e && v1) q.push_back(mk(1));
      end
   endtask
   task automatic cycle();
      #1 compare();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask
   task automatic pack(input logic a, input logic b, input logic [63:0] p);
      fv = 1; v0 = a; v1 = b; pc = p;
      i0 = $urandom; i1 = $urandom; tgt = {$urandom, $urandom}; typ = 4'($urandom);
      bpv = 0; bpt = 0; bps = 0;
   endtask
   initial begin
      {flush, fv, v0, v1, bpv, bpt, bps, dr} = '0;
      pc = '0; tgt = '0; i0 = '0; i1 = '0; typ = '0;
      repeat (2) @(negedge clock);
      #1 compare();
      @(negedge clock);
      reset = 1;
      @(negedge clock);
      pack(1, 1, 64'h80000000); i0 = 32'h00000013; i1 = 32'h00100093;
      cycle();
      fv = 0;
      check("tp_valid_1", valid_1, 1);
      check("tp_pc_0", pc_0, 64'h80000000);
      check("tp_pc_1", pc_1, 64'h80000004);
      pack(0, 1, 64'h80000008); dr = 1;
      cycle();
      check("compact_pc_0", pc_0, 64'h8000000C);
      check("compact_valid_1", valid_1, 0);
      pack(1, 1, 64'h80000010); bpv = 1; bpt = 1; bps = 0; tgt = 64'h80001000;
      cycle();
      fv = 0; dr = 0;
      check("pred_taken_0", taken_0, 1);
      check("pred_target_0", target_0, 64'h80001000);
      check("pred_taken_1", taken_1, 0);
      flush = 1; cycle(); flush = 0;
      for (int i = 0; i < 9; i++) begin
         pack(1, 1, 64'h90000000 + 64'(8 * i));
         cycle();
         if (i == 7) check("fill_stall", stall, 1);
      end
      fv = 0; dr = 1; cycle(); dr = 0;
      check("drain_stall", stall, 0);
      dr = 1; repeat (4) cycle();
      pack(1, 1, 64'hA0000000); flush = 1;
      cycle();
      {flush, fv, dr} = '0;
      check("post_flush_valid_0", valid_0, 0);
      for (int i = 0; i < 40; i++) begin
         pack(1, 1, 64'hB0000000 + 64'(8 * i)); dr = 1;
         cycle();
      end
      dr = 0; repeat (3) cycle();
      fv = 0;
      #2 reset = 0;
      #1 check("async_valid_0", valid_0, 0);
      check("async_valid_1", valid_1, 0);
      check("async_stall", stall, 0);
      q.delete();
      @(negedge clock);
      reset = 1;
      for (int i = 0; i < 600; i++) begin
         pack(1'($urandom), 1'($urandom), {$urandom, $urandom} & ~64'h7);
         fv = $urandom_range(0, 9) < 7;
         bpv = 1'($urandom); bpt = 1'($urandom); bps = 1'($urandom);
         dr = $urandom_range(0, 9) < 5;
         flush = $urandom_range(0, 29) == 0;
         cycle();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
